schematic_misterioso: RTL and testbench
=======================================

Name: schematic_misterioso

Overview:
- Parameterised shift register with synchronous parallel load and serial shift (default 3 bits).
- Each cycle it clears, loads a parallel word, or shifts one bit toward the LSB; the vacated MSB takes the serial input.
- The LSB is presented as the serial output.
- Used as a generic serializer/deserializer stage in the datapath.

Parameters:
- WIDTH, 3, register width in bits (q and d). Legal range 2 or more.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clrn  input  1  reset; synchronous, active-high. The port keeps the codebase name clrn despite the suffix. 1 at a rising edge clears the register.
- d  input  WIDTH  parallel load data.
- di  input  1  serial data in; enters the MSB on a shift.
- load  input  1  1 = parallel load d; 0 = shift.
- q  output  WIDTH  register contents, registered.
- do  output  1  serial out; combinationally equal to q[0].

Behaviour:
- Single register q[WIDTH-1:0]. All updates occur only on the rising edge of clk, with priority below.
  1. clrn == 1: q <= 0. This overrides load and shift.
  2. else if load == 1: q <= d.
  3. else: q <= {di, q[WIDTH-1:1]}. This is a logical right shift with di into the MSB; the old q[0] is discarded after appearing on do.
- do = q[0] at all times, combinational from the register. No extra latency.
- Latency: one clock edge from load/d/di/clrn to q.
- Reset value: q = 0 and do = 0.
- No asynchronous behaviour. Asserting clrn between edges does not change q until the next rising edge.
- Power-up before the first reset edge: q is unspecified. The bench must apply clrn for at least one edge before checking.
- Reset mid-shift or mid-load: clrn wins and the operation in that cycle is lost.
- Shift continues every cycle while load == 0 and clrn == 0. There is no hold/enable mode.
- With di held constant, q saturates to all-di after WIDTH shifts.
- The next state depends only on the input values sampled at the edge. Inputs changing with no edge have no effect.
- X on load or clrn at an edge is a bench error. The design needs no special handling.

Test Plan:
- Reset: clrn=1, load=0, d=101, di=1 for 2 edges -> q=000, do=0. Reset dominates the shift.
- Reset vs load: clrn=1, load=1, d=101 at one edge -> q=000 (clear has priority).
- Parallel load: clrn=0, load=1, d=101 at one edge -> q=101, do=1. Then d=010 at the next edge -> q=010, do=0.
- Shift in ones: from q=101, load=0, di=1 over 3 edges -> q=110, 111, 111; do=0, 1, 1.
- Shift in zeros: from q=101, load=0, di=0 over 3 edges -> q=010, 001, 000; do sequence 0, 1, 0 (the serialised word LSB-first after the first shift).
- Mid-operation reset: load 111, shift one edge with di=0 (q=011), then clrn=1 at the next edge -> q=000. Release clrn with load=0, di=1 -> next edge q=100, do=0.

Source files
------------

// File: rtl/schematic_misterioso.sv
// Parameterised shift register: synchronous clear, parallel load, or a
// right shift with serial input into the MSB. The LSB is the serial output.
module schematic_misterioso #(
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_clrn,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_di,
  input  logic             i_load,
  output logic [WIDTH-1:0] o_q,
  output logic             o_do
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shift;

  // Old LSB falls off the bottom; it was already visible on o_do.
  assign w_shift = {i_di, r_q[WIDTH-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_clrn) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else begin
      r_q <= w_shift;
    end
  end

  assign o_q  = r_q;
  assign o_do = r_q[0];

endmodule

// File: tb/tb_schematic_misterioso.sv
// Self-checking bench for schematic_misterioso: directed literal checks plus
// randomized traffic compared every cycle against an arithmetic model.
module tb_schematic_misterioso;

  localparam int W = 3;

  logic         clk;
  logic         i_clrn;
  logic [W-1:0] i_d;
  logic         i_di;
  logic         i_load;
  logic [W-1:0] o_q;
  logic         o_do;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           model_val;
  bit           model_ok = 1'b0;

  schematic_misterioso #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_clrn (i_clrn),
    .i_d    (i_d),
    .i_di   (i_di),
    .i_load (i_load),
    .o_q    (o_q),
    .o_do   (o_do)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register value as an integer; a shift is a halving
  // plus the weight of the MSB when the serial input is 1.
  always @(posedge clk) begin
    if (i_clrn === 1'b1) begin
      model_val = 0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (i_load) model_val = int'(i_d);
      else        model_val = (model_val / 2) + (i_di ? (1 << (W - 1)) : 0);
    end
    if (model_ok) exp_q.push_back(model_val[W-1:0]);
  end

  // Scoreboard compare on the opposite edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (o_q !== e || o_do !== e[0]) begin
        errors++;
        $display("FAIL model t=%0t q=%b do=%b expected q=%b do=%b",
                 $time, o_q, o_do, e, e[0]);
      end
    end
  end

  // driver tasks
  task automatic step(input logic c, input logic l, input logic [W-1:0] dv,
                      input logic div);
    i_clrn = c;
    i_load = l;
    i_d    = dv;
    i_di   = div;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] eq, input logic ed);
    checks++;
    if (o_q !== eq || o_do !== ed) begin
      errors++;
      $display("FAIL %s q=%b do=%b expected q=%b do=%b", name, o_q, o_do, eq, ed);
    end
  endtask

  initial begin
    i_clrn = 1'b1;
    i_load = 1'b0;
    i_d    = 3'b101;
    i_di   = 1'b1;

    // Reset dominates shift
    step(1'b1, 1'b0, 3'b101, 1'b1); chk("reset_1", 3'b000, 1'b0);
    step(1'b1, 1'b0, 3'b101, 1'b1); chk("reset_2", 3'b000, 1'b0);
    // Reset dominates load
    step(1'b1, 1'b1, 3'b101, 1'b0); chk("reset_vs_load", 3'b000, 1'b0);
    // Parallel load
    step(1'b0, 1'b1, 3'b101, 1'b0); chk("load_101", 3'b101, 1'b1);
    step(1'b0, 1'b1, 3'b010, 1'b0); chk("load_010", 3'b010, 1'b0);
    // Shift in ones
    step(1'b0, 1'b1, 3'b101, 1'b0); chk("load_101b", 3'b101, 1'b1);
    step(1'b0, 1'b0, 3'b000, 1'b1); chk("shift1_a", 3'b110, 1'b0);
    step(1'b0, 1'b0, 3'b000, 1'b1); chk("shift1_b", 3'b111, 1'b1);
    step(1'b0, 1'b0, 3'b000, 1'b1); chk("shift1_c", 3'b111, 1'b1);
    // Shift in zeros
    step(1'b0, 1'b1, 3'b101, 1'b0); chk("load_101c", 3'b101, 1'b1);
    step(1'b0, 1'b0, 3'b111, 1'b0); chk("shift0_a", 3'b010, 1'b0);
    step(1'b0, 1'b0, 3'b111, 1'b0); chk("shift0_b", 3'b001, 1'b1);
    step(1'b0, 1'b0, 3'b111, 1'b0); chk("shift0_c", 3'b000, 1'b0);
    // Mid-operation reset
    step(1'b0, 1'b1, 3'b111, 1'b0); chk("load_111", 3'b111, 1'b1);
    step(1'b0, 1'b0, 3'b000, 1'b0); chk("mid_shift", 3'b011, 1'b1);
    step(1'b1, 1'b0, 3'b000, 1'b0); chk("mid_reset", 3'b000, 1'b0);
    step(1'b0, 1'b0, 3'b000, 1'b1); chk("after_reset", 3'b100, 1'b0);
    // A clear pulse between edges must have no effect
    step(1'b0, 1'b1, 3'b101, 1'b0); chk("load_101d", 3'b101, 1'b1);
    i_load = 1'b0;
    i_di   = 1'b0;
    i_clrn = 1'b1;
    #3;
    i_clrn = 1'b0;
    @(posedge clk);
    #1;
    chk("glitch_clr", 3'b010, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)));
    end
    // Long same-bit runs to show saturation
    for (int n = 0; n < 2 * W; n++) step(1'b0, 1'b0, '0, 1'b1);
    chk("saturate_1", {W{1'b1}}, 1'b1);
    for (int n = 0; n < 2 * W; n++) step(1'b0, 1'b0, '0, 1'b0);
    chk("saturate_0", {W{1'b0}}, 1'b0);

    @(negedge clk);
    @(negedge clk);
    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
